alu_operand_entry: RTL and testbench
====================================

Name: alu_operand_entry

Overview:
- Front-end command source for the `operations` ALU block.
- Lets a user key in operand A, operand B and the 3-bit op code, one at a time, from board switches and a single push button.
- Drives the `A`, `B` and `control` inputs of `operations` and pulses a one-cycle command strobe when a full command is committed.
- It is the writer side of the ALU command interface; `operations` is the reader.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples needed before a button level change is accepted (min 2).
- CNT_WIDTH, 8, width of the issued-command counter.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- sw  input  6  operand switches; quasi-static, sampled only on a press event.
- op_sw  input  3  op-code switches (000 add, 001 sub, 100 eq, 101 gt, 110 lt, 111 eq-zero).
- btn  input  1  raw, asynchronous, bouncing push button; active-high.
- A  output  6  registered operand A to the ALU.
- B  output  6  registered operand B to the ALU.
- control  output  3  registered op code to the ALU.
- cmd_valid  output  1  one-cycle strobe, high in the cycle the new `control` first appears.
- stage  output  2  current entry state: 0 = A, 1 = B, 2 = OP, 3 = SHOW.
- cmd_count  output  CNT_WIDTH  number of commands issued; wraps.

Behaviour:
- Reset, asynchronous on reset=0: A=0, B=0, control=000, cmd_valid=0, stage=0, cmd_count=0.
  - Synchronizer flops, debounce counter and stable level also clear to 0.
- Reset asserted mid-entry discards partial A/B without issuing a command.
- Button path:
  - `btn` passes through a 2-flop synchronizer.
  - Debounce counter increments while synced level ≠ stable level.
  - Counter clears whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, stable takes the synced level and the counter clears.
  - Press event: one-cycle pulse on a 0→1 transition of stable.
  - Latency from a clean raw rising edge to the press pulse is 2+DEBOUNCE_CYCLES cycles.
  - A held button yields exactly one event; release yields none.
- FSM, advancing only on a press event (otherwise hold):
  - S_A (stage 0): A <= operand(sw); go to S_B.
  - S_B (stage 1): B <= operand(sw); go to S_OP.
  - S_OP (stage 2): control <= op_sw; cmd_valid <= 1 for one cycle; cmd_count <= cmd_count+1; go to S_SHOW.
  - S_SHOW (stage 3): go to S_A. A/B/control are retained so the ALU keeps displaying the last result.
- Output hold: A, B and control change only on their own commit edge. They hold their value throughout entry of later fields.
  - The ALU therefore sees the new A (and B) before the new control. Consumers must treat cmd_valid as the commit point.
- cmd_valid is a registered output. It is never high for two consecutive cycles; the minimum spacing between strobes is 4 press events.
- cmd_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Undefined op codes (010, 011) are passed through unchanged; no checking.
- The `sw`/`op_sw` value used is the one present in the press-pulse cycle.

Optional Feature:
- Macro: SIGN_MAG_ENTRY_EN.
- Defined: operand(sw) treats sw[5] as sign and sw[4:0] as magnitude, and converts to 6-bit two's complement.
  - Range is -31..+31.
  - -0 (6'b100000) maps to 6'b000000.
- Not defined: operand(sw) = sw, raw two's complement, range -32..+31.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. Hold reset=0 for 3 cycles, then release → A=0, B=0, control=000, cmd_valid=0, stage=0, cmd_count=0.
2. Press with sw=20, press with sw=1, press with op_sw=101 → A=20, B=1, control=101.
   - cmd_valid is high exactly one cycle, 6 cycles after the third clean edge.
   - stage=3, cmd_count=1.
3. Bounce: btn high 2 cycles, low 3, high 1, then low → no press event; stage stays 0 and A is unchanged.
4. Hold btn high for 100 cycles in stage 0 with sw=7 → exactly one advance; A=7, stage=1.
5. Reach stage 2 with A=1, B=20 loaded, then pull reset=0 → all outputs return to reset values immediately (asynchronously) and cmd_valid is never asserted.
6. Issue 256 full commands (op 000, A=0, B=1) → cmd_count returns to 0. With SIGN_MAG_ENTRY_EN defined, sw=6'b100101 in S_A gives A=6'b111011 (-5); without the macro it gives A=6'b100101.

Source files
------------

// File: rtl/alu_operand_entry_if.sv
// ALU command bus between the operand entry front end (writer) and the
// `operations` ALU (reader). The writer owns every signal on the bus.
interface alu_operand_entry_if;

  localparam int unsigned OPND_W = 6;
  localparam int unsigned OP_W   = 3;

  logic [OPND_W-1:0] A;          // operand A
  logic [OPND_W-1:0] B;          // operand B
  logic [OP_W-1:0]   control;    // op code
  logic              cmd_valid;  // one-cycle commit strobe, aligned with a new control

  // Writer side: operand entry block
  modport master (
    output A,
    output B,
    output control,
    output cmd_valid
  );

  // Reader side: ALU
  modport slave (
    input A,
    input B,
    input control,
    input cmd_valid
  );

endinterface : alu_operand_entry_if

// File: rtl/alu_operand_entry.sv
// Switch/push-button command entry for the `operations` ALU.
// The user keys operand A, operand B and the op code in turn; every debounced
// button press advances one field, and committing the op code pulses cmd_valid.
// Optional feature macro: SIGN_MAG_ENTRY_EN -- when defined the operand
// switches are read as sign/magnitude (sw[5] sign, sw[4:0] magnitude) and
// converted to two's complement; otherwise sw is taken as raw two's complement.
module alu_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,  // stable samples to accept a level change, >= 2
  parameter int unsigned CNT_WIDTH       = 8    // issued-command counter width
) (
  input  logic                 clock,
  input  logic                 reset,      // asynchronous, active-low
  input  logic [5:0]           sw,
  input  logic [2:0]           op_sw,
  input  logic                 btn,        // raw, bouncing, active-high
  alu_operand_entry_if.master  alu,
  output logic [1:0]           stage,
  output logic [CNT_WIDTH-1:0] cmd_count
);

  localparam int unsigned OPND_W   = 6;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned DEB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path: synchronizer, debounce and press detection
  // ---------------------------------------------------------------------------
  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;
  logic             press_c;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it persists; the press event is
  // the cycle in which the stable level is about to rise, so the FSM commits
  // on the same edge that stable goes high and holding the button cannot retrigger.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    press_c   = 1'b0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = sync2_q;
        press_c  = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand conversion from the switch encoding to two's complement
  // ---------------------------------------------------------------------------
  function automatic logic [OPND_W-1:0] to_operand(input logic [OPND_W-1:0] s);
`ifdef SIGN_MAG_ENTRY_EN
    logic [OPND_W-1:0] mag;
    mag = {1'b0, s[OPND_W-2:0]};
    // Negating a zero magnitude wraps back to zero, so -0 reads as 0.
    return s[OPND_W-1] ? (~mag + OPND_W'(1)) : mag;
`else
    return s;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Entry FSM with registered bus outputs
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic [OPND_W-1:0]     a_q;
  logic [OPND_W-1:0]     b_q;
  logic [OP_W-1:0]       ctl_q;
  logic                  cmd_valid_q;
  logic [CNT_WIDTH-1:0]  cmd_count_q;

  // Advance one field per press; fields hold until their own commit edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      ctl_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (press_c) begin
        unique case (state_q)
          S_A: begin
            a_q     <= to_operand(sw);
            state_q <= S_B;
          end
          S_B: begin
            b_q     <= to_operand(sw);
            state_q <= S_OP;
          end
          S_OP: begin
            ctl_q       <= op_sw;
            cmd_valid_q <= 1'b1;
            cmd_count_q <= cmd_count_q + CNT_WIDTH'(1);
            state_q     <= S_SHOW;
          end
          S_SHOW: begin
            state_q <= S_A;
          end
          default: begin
            state_q <= S_A;
          end
        endcase
      end
    end
  end

  // Output mapping
  assign alu.A         = a_q;
  assign alu.B         = b_q;
  assign alu.control   = ctl_q;
  assign alu.cmd_valid = cmd_valid_q;
  assign stage         = state_q;
  assign cmd_count     = cmd_count_q;

endmodule : alu_operand_entry

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry with DEBOUNCE_CYCLES=4: vector table for fixed
// commands, hand sequences for bounce/hold/reset, and random presses checked
// against an abstract entry model.
module tb_alu_operand_entry;

  localparam int unsigned DEB  = 4;
  localparam int unsigned CNTW = 8;

  logic            clock;
  logic            reset;
  logic [5:0]      sw;
  logic [2:0]      op_sw;
  logic            btn;
  logic [1:0]      stage;
  logic [CNTW-1:0] cmd_count;

  alu_operand_entry_if alu_if ();

  alu_operand_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CNTW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sw       (sw),
    .op_sw    (op_sw),
    .btn      (btn),
    .alu      (alu_if),
    .stage    (stage),
    .cmd_count(cmd_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_total = 0;
  logic prev_valid = 1'b0;

  // Model: which field is next, and the values the ALU should be seeing
  int         m_stage;
  logic [5:0] m_a;
  logic [5:0] m_b;
  logic [2:0] m_ctl;
  int         m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_operand(input logic [5:0] s);
    int v;
`ifdef SIGN_MAG_ENTRY_EN
    v = s[5] ? -int'(s[4:0]) : int'(s[4:0]);
`else
    v = s[5] ? int'(s) - 64 : int'(s);
`endif
    return 6'(v);
  endfunction

  // A strobe must never follow a strobe
  always @(negedge clock) begin
    if (alu_if.cmd_valid) begin
      strobe_total++;
      chk("cmd_valid_back_to_back", int'(prev_valid), 0);
    end
    prev_valid = alu_if.cmd_valid;
  end

  task automatic model_reset();
    m_stage = 0; m_a = '0; m_b = '0; m_ctl = '0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_stage"},   int'(stage),          m_stage);
    chk({tag, "_A"},       int'(alu_if.A),       int'(m_a));
    chk({tag, "_B"},       int'(alu_if.B),       int'(m_b));
    chk({tag, "_control"}, int'(alu_if.control), int'(m_ctl));
    chk({tag, "_count"},   int'(cmd_count),      m_cnt);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Clean press and release; checks strobe timing and field commits
  task automatic do_press(input logic [5:0] s, input logic [2:0] o);
    int hits, first, rel_hits, st;
    hits = 0; first = -1; rel_hits = 0;
    @(negedge clock);
    sw = s; op_sw = o; btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (alu_if.cmd_valid) begin
        hits++;
        if (first < 0) first = k;
      end
    end
    btn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (alu_if.cmd_valid) rel_hits++;
    end
    st = m_stage;
    case (st)
      0: m_a = model_operand(s);
      1: m_b = model_operand(s);
      2: begin m_ctl = o; m_cnt = (m_cnt + 1) % (1 << CNTW); end
      default: ;
    endcase
    m_stage = (st + 1) % 4;
    chk("strobes_per_press", hits, (st == 2) ? 1 : 0);
    if (st == 2) chk("strobe_latency", first, 2 + DEB);
    chk("strobes_on_release", rel_hits, 0);
    check_outputs("press");
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  typedef struct {
    logic [5:0] sw_a;
    logic [5:0] sw_b;
    logic [2:0] op;
    logic [5:0] exp_a;
    logic [5:0] exp_b;
    logic [2:0] exp_ctl;
  } vec_t;

  vec_t vecs [4];
  logic [2:0] ops [8];

  initial begin
    int changes, strobes_before;
    logic [1:0] prev_stage;
    logic [5:0] neg5;

    vecs[0] = '{sw_a: 6'd20, sw_b: 6'd1,  op: 3'b101, exp_a: 6'd20, exp_b: 6'd1,  exp_ctl: 3'b101};
    vecs[1] = '{sw_a: 6'd31, sw_b: 6'd31, op: 3'b000, exp_a: 6'd31, exp_b: 6'd31, exp_ctl: 3'b000};
    vecs[2] = '{sw_a: 6'd0,  sw_b: 6'd17, op: 3'b010, exp_a: 6'd0,  exp_b: 6'd17, exp_ctl: 3'b010};
    vecs[3] = '{sw_a: 6'd3,  sw_b: 6'd9,  op: 3'b111, exp_a: 6'd3,  exp_b: 6'd9,  exp_ctl: 3'b111};
    ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

    sw = '0; op_sw = '0; btn = 1'b0; reset = 1'b0;
    model_reset();

    // Reset values
    cycles(3);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_valid", int'(alu_if.cmd_valid), 0);
    check_outputs("reset");

    // Bounce shorter than the debounce window produces no press
    sw = 6'd9;
    btn = 1'b1; cycles(2);
    btn = 1'b0; cycles(3);
    btn = 1'b1; cycles(1);
    btn = 1'b0; cycles(12);
    chk("bounce_strobes", strobe_total, 0);
    check_outputs("bounce");

    // Table of full commands, then the SHOW press returns to stage 0
    foreach (vecs[i]) begin
      do_press(vecs[i].sw_a, 3'b000);
      do_press(vecs[i].sw_b, 3'b000);
      chk("vec_A_before_op", int'(alu_if.A), int'(vecs[i].exp_a));
      do_press(6'd0, vecs[i].op);
      chk("vec_A", int'(alu_if.A), int'(vecs[i].exp_a));
      chk("vec_B", int'(alu_if.B), int'(vecs[i].exp_b));
      chk("vec_control", int'(alu_if.control), int'(vecs[i].exp_ctl));
      chk("vec_stage", int'(stage), 3);
      chk("vec_count", int'(cmd_count), i + 1);
      do_press(6'd0, 3'b000);
    end

    // Long hold advances exactly once
    @(negedge clock);
    sw = 6'd7; btn = 1'b1;
    changes = 0; prev_stage = stage;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (stage != prev_stage) changes++;
      prev_stage = stage;
    end
    btn = 1'b0; cycles(10);
    m_a = model_operand(6'd7); m_stage = 1;
    chk("hold_advances", changes, 1);
    check_outputs("hold");

    // Asynchronous reset mid-entry discards partial fields, no strobe
    apply_reset();
    do_press(6'd1, 3'b000);
    do_press(6'd20, 3'b000);
    chk("mid_stage", int'(stage), 2);
    strobes_before = strobe_total;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    chk("async_reset_valid", int'(alu_if.cmd_valid), 0);
    cycles(3);
    reset = 1'b1;
    cycles(12);
    chk("no_strobe_after_reset", strobe_total - strobes_before, 0);
    check_outputs("post_reset");

    // Counter wrap after 256 commands
    for (int n = 0; n < 256; n++) begin
      do_press(6'd0, 3'b000);
      do_press(6'd1, 3'b000);
      do_press(6'd0, 3'b000);
      do_press(6'd0, 3'b000);
    end
    chk("count_wrapped", int'(cmd_count), 0);

    // Operand encoding of 6'b100101
    do_press(6'b100101, 3'b000);
`ifdef SIGN_MAG_ENTRY_EN
    neg5 = 6'b111011;
`else
    neg5 = 6'b100101;
`endif
    chk("operand_encoding", int'(alu_if.A), int'(neg5));

    // Random presses against the model, including -0 in sign/magnitude form
    do_press(6'b100000, 3'b000);
    for (int n = 0; n < 24; n++) begin
      do_press(6'($urandom_range(0, 63)), ops[$urandom_range(0, 7)]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_operand_entry
